// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU type definitions.
//   pipectrl_state_t : pipeline controller FSM states
//     RUN       - normal issue
//     DWAIT     - pipeline frozen on an outstanding data access
//     FETCHSTOP - halt seen in ID/EX, fetch suppressed while it drains
//     HALT      - halt retired, core frozen until reset
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DWAIT     = 2'd1,
    FETCHSTOP = 2'd2,
    HALT      = 2'd3
  } pipectrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Hazard / stall / flush controller for a 5-stage pipeline.
//
// Optional feature macro: PIPECTRL_PERF_EN (adds stall_cnt / flush_cnt).
//
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   ihit, dhit          instruction fetch / data access completed this cycle
//   xmem_dreq           EX/MEM holds a load or store
//   br_taken            taken branch resolved in MEM
//   idex_memread        ID/EX holds a load
//   idex_rt             destination of the load in ID/EX
//   ifid_rs, ifid_rt    source registers of the instruction in IF/ID
//   idex_halt_in        halt decoded in ID
//   mwb_halt_out        halt reached WB
//   pc_WEN              PC update enable
//   *_WEN / *_flush     per pipeline register enable / flush (flush wins)
//   halted              core halted (sticky until reset)
//   stall_cnt           cycles with PC held (PIPECTRL_PERF_EN only)
//   flush_cnt           taken-branch flush cycles (PIPECTRL_PERF_EN only)
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             xmem_dreq,
  input  logic             br_taken,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_halt_in,
  input  logic             mwb_halt_out,
  output logic             pc_WEN,
  output logic             ifid_WEN,
  output logic             ifid_flush,
  output logic             idex_WEN,
  output logic             idex_flush,
  output logic             xmem_WEN,
  output logic             xmem_flush,
  output logic             mwb_WEN,
  output logic             mwb_flush,
`ifdef PIPECTRL_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
`endif
  output logic             halted
);

  pipectrl_state_t state, state_next;
  logic            ret_fs, ret_fs_next;
  logic            fetch_stopped;
  logic            data_wait;
  logic            load_use;

  // A load in ID/EX whose destination is read by the instruction in IF/ID.
  // Register zero never carries a dependency.
  function automatic logic load_use_hazard(input logic       memread,
                                           input logic [4:0] ld_rt,
                                           input logic [4:0] use_rs,
                                           input logic [4:0] use_rt);
    return memread && (ld_rt != REG_ZERO) &&
           ((ld_rt == use_rs) || (ld_rt == use_rt));
  endfunction

  // DWAIT does not encode where it came from, so ret_fs remembers whether
  // the freeze began in FETCHSTOP; the dhit cycle is then evaluated in that
  // mode. Inside DWAIT only dhit matters, the request is known to be pending.
  assign fetch_stopped = (state == FETCHSTOP) || ((state == DWAIT) && ret_fs);
  assign data_wait     = (state == DWAIT) ? !dhit : (xmem_dreq && !dhit);
  assign load_use      = load_use_hazard(idex_memread, idex_rt, ifid_rs, ifid_rt);
  assign halted        = (state == HALT) && !RST;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      ret_fs <= 1'b0;
    end else begin
      state  <= state_next;
      ret_fs <= ret_fs_next;
    end
  end

  // Priority resolution: halt > data wait > branch > load-use > fetch
  // miss / fetch stop > normal. In FETCHSTOP the IF/ID contents are
  // wrong-path, so IF/ID is flushed even under a load-use hold.
  always_comb begin
    state_next  = state;
    ret_fs_next = ret_fs;
    pc_WEN      = 1'b1;
    ifid_WEN    = 1'b1;
    idex_WEN    = 1'b1;
    xmem_WEN    = 1'b1;
    mwb_WEN     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    xmem_flush  = 1'b0;
    mwb_flush   = 1'b0;
    if (RST) begin
      pc_WEN      = 1'b0;
      ifid_WEN    = 1'b0;
      idex_WEN    = 1'b0;
      xmem_WEN    = 1'b0;
      mwb_WEN     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      xmem_flush  = 1'b1;
      mwb_flush   = 1'b1;
      state_next  = RUN;
      ret_fs_next = 1'b0;
    end else if ((state == HALT) || mwb_halt_out) begin
      pc_WEN     = 1'b0;
      ifid_WEN   = 1'b0;
      idex_WEN   = 1'b0;
      xmem_WEN   = 1'b0;
      mwb_WEN    = 1'b0;
      state_next = HALT;
    end else if (data_wait) begin
      pc_WEN      = 1'b0;
      ifid_WEN    = 1'b0;
      idex_WEN    = 1'b0;
      xmem_WEN    = 1'b0;
      mwb_WEN     = 1'b0;
      state_next  = DWAIT;
      ret_fs_next = fetch_stopped;
    end else if (br_taken) begin
      // A taken branch also cancels a speculative halt behind it.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      xmem_flush = 1'b1;
      state_next = RUN;
    end else if (load_use) begin
      pc_WEN     = 1'b0;
      ifid_WEN   = 1'b0;
      idex_flush = 1'b1;
      ifid_flush = fetch_stopped;
      state_next = fetch_stopped ? FETCHSTOP : RUN;
    end else begin
      if (fetch_stopped || !ihit) begin
        pc_WEN     = 1'b0;
        ifid_flush = 1'b1;
      end
      // The halt only sticks once it has actually moved into ID/EX.
      state_next = (fetch_stopped || idex_halt_in) ? FETCHSTOP : RUN;
    end
  end

`ifdef PIPECTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic branch_flush;

  assign branch_flush = !RST && (state != HALT) && !mwb_halt_out &&
                        !data_wait && br_taken;

  // Performance counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_WEN && (state != HALT)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (branch_flush) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// randomized cycles, all compared against a cycle-level reference model
// that tracks the pipeline mode with plain flags and counters.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit, xmem_dreq, br_taken, idex_memread;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       idex_halt_in, mwb_halt_out;
  logic       pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush;
  logic       xmem_WEN, xmem_flush, mwb_WEN, mwb_flush, halted;
`ifdef PIPECTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: halted / waiting-on-data / fetch-stopped flags.
  localparam int K_RST = 0, K_HALT = 1, K_DWAIT = 2, K_BR = 3, K_LU = 4, K_NORM = 5;
  bit          m_halted, m_waiting, m_fs;
  int unsigned m_stall, m_flush;
  int          kind;
  logic [8:0]  exp_ctrl;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ihit         (ihit),
    .dhit         (dhit),
    .xmem_dreq    (xmem_dreq),
    .br_taken     (br_taken),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .idex_halt_in (idex_halt_in),
    .mwb_halt_out (mwb_halt_out),
    .pc_WEN       (pc_WEN),
    .ifid_WEN     (ifid_WEN),
    .ifid_flush   (ifid_flush),
    .idex_WEN     (idex_WEN),
    .idex_flush   (idex_flush),
    .xmem_WEN     (xmem_WEN),
    .xmem_flush   (xmem_flush),
    .mwb_WEN      (mwb_WEN),
    .mwb_flush    (mwb_flush),
`ifdef PIPECTRL_PERF_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .halted       (halted)
  );

  always #5 CLK = ~CLK;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected controls for the current inputs, straight from the priority list.
  task automatic modelEval();
    logic hazard;
    hazard = idex_memread && (idex_rt != 5'd0) &&
             ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    if (RST)                                  kind = K_RST;
    else if (m_halted || mwb_halt_out)        kind = K_HALT;
    else if (!dhit && (m_waiting || xmem_dreq)) kind = K_DWAIT;
    else if (br_taken)                        kind = K_BR;
    else if (hazard)                          kind = K_LU;
    else                                      kind = K_NORM;
    // bit order: pc, ifid W/F, idex W/F, xmem W/F, mwb W/F
    case (kind)
      K_RST:          exp_ctrl = 9'b0_0_1_0_1_0_1_0_1;
      K_HALT, K_DWAIT: exp_ctrl = 9'b0;
      K_BR:           exp_ctrl = 9'b1_1_1_1_1_1_1_1_0;
      K_LU:           exp_ctrl = {1'b0, 1'b0, m_fs, 6'b1_1_1_0_1_0};
      default:        exp_ctrl = {(!m_fs && ihit), 1'b1, (m_fs || !ihit), 6'b1_0_1_0_1_0};
    endcase
  endtask

  task automatic modelCommit();
    if (kind == K_RST) begin
      m_halted = 0; m_waiting = 0; m_fs = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!m_halted && !exp_ctrl[8]) m_stall++;
      case (kind)
        K_HALT:  m_halted = 1;
        K_DWAIT: m_waiting = 1;
        K_BR:    begin m_waiting = 0; m_fs = 0; m_flush++; end
        K_LU:    m_waiting = 0;
        default: begin m_waiting = 0; if (idex_halt_in) m_fs = 1; end
      endcase
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".ctrl"}, {23'd0, pc_WEN, ifid_WEN, ifid_flush, idex_WEN, idex_flush,
                                xmem_WEN, xmem_flush, mwb_WEN, mwb_flush}, {23'd0, exp_ctrl});
  endtask

  task automatic checkRegistered(input string tag);
    checkValue({tag, ".halted"}, {31'd0, halted}, {31'd0, (m_halted && !RST)});
`ifdef PIPECTRL_PERF_EN
    checkValue({tag, ".stall_cnt"}, stall_cnt, m_stall);
    checkValue({tag, ".flush_cnt"}, flush_cnt, m_flush);
`endif
  endtask

  // Drive one cycle: check combinational controls mid-cycle, then the
  // registered outputs just after the edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic ih,
                               input logic dh, input logic dreq, input logic br,
                               input logic mrd, input logic [4:0] rt, input logic [4:0] rs,
                               input logic [4:0] irt, input logic hin, input logic mh);
    RST = rst; ihit = ih; dhit = dh; xmem_dreq = dreq; br_taken = br;
    idex_memread = mrd; idex_rt = rt; ifid_rs = rs; ifid_rt = irt;
    idex_halt_in = hin; mwb_halt_out = mh;
    #2;
    modelEval();
    checkOutput(tag);
    @(posedge CLK);
    #1;
    modelCommit();
    checkRegistered(tag);
  endtask

  task automatic normalCycle(input string tag);
    applyStimulus(tag, 0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic resetCycle(input string tag);
    applyStimulus(tag, 1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    resetCycle("reset0");
    resetCycle("reset1");
    normalCycle("post_reset");

    // Data wait: three missing cycles then the hit.
    resetCycle("dw.reset");
    for (int i = 0; i < 3; i++)
      applyStimulus("dw.miss", 0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    applyStimulus("dw.hit", 0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
`ifdef PIPECTRL_PERF_EN
    checkValue("dw.stall_total", stall_cnt, 32'd3);
`endif
    normalCycle("dw.after");

    // Load-use on rs, then the same with rt=0.
    applyStimulus("lu.hit", 0, 1, 1, 0, 0, 1, 5'd5, 5'd5, 5'd2, 0, 0);
    normalCycle("lu.after");
    applyStimulus("lu.r0", 0, 1, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
    applyStimulus("lu.miss", 0, 0, 1, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0);

    // Taken branch during a fetch miss.
    resetCycle("br.reset");
    applyStimulus("br.taken", 0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
`ifdef PIPECTRL_PERF_EN
    checkValue("br.flush_total", flush_cnt, 32'd1);
`endif

    // Speculative halt cancelled by a branch two cycles later.
    applyStimulus("fs.enter", 0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0);
    applyStimulus("fs.hold", 0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    applyStimulus("fs.branch", 0, 1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    normalCycle("fs.run");

    // Halt beats a same-cycle dhit and branch, and sticks until reset.
    applyStimulus("halt.enter", 0, 1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    checkValue("halt.flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 3; i++)
      applyStimulus("halt.hold", 0, 0, 1, 1, 1, 1, 5'd3, 5'd3, 5'd0, 0, 0);
    resetCycle("halt.reset");
    normalCycle("halt.after");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, which sets the width of the performance counters.
REQ-002 SHALL have these ports (one per line: name, direction, width, meaning):
- CLK, in, 1, single clock, rising edge.
- RST, in, 1, reset; synchronous, active-high.
- ihit, in, 1, instruction fetch complete this cycle.
- dhit, in, 1, data access complete this cycle.
- xmem_dreq, in, 1, EX/MEM M_MemRead_out | M_MemWrite_out.
- br_taken, in, 1, EX/MEM M_Branch_out & alu_zero_out (resolved in MEM).
- idex_memread, in, 1, ID/EX M_MemRead_out.
- idex_rt, in, 5, ID/EX rt_out.
- ifid_rs, in, 5, rs field of IF/ID instruction_out.
- ifid_rt, in, 5, rt field of IF/ID instruction_out.
- idex_halt_in, in, 1, halt decoded in ID.
- mwb_halt_out, in, 1, halt reached WB.
- pc_WEN, out, 1, PC update enable.
- ifid_WEN / ifid_flush, out, 1 each, IF/ID controls.
- idex_WEN / idex_flush, out, 1 each, ID/EX controls.
- xmem_WEN / xmem_flush, out, 1 each, EX/MEM controls.
- mwb_WEN / mwb_flush, out, 1 each, MEM/WB controls.
- halted, out, 1, core halted (sticky).
- stall_cnt, out, CNT_W, stall cycle count (only when PIPECTRL_PERF_EN).
- flush_cnt, out, CNT_W, flush event count (only when PIPECTRL_PERF_EN).

Function
REQ-003 SHALL implement FSM states RUN, DWAIT, FETCHSTOP, HALT; control outputs are combinational from state and inputs and take effect at the next CLK edge; flush has priority over WEN inside each register.
REQ-004 SHALL apply these cycle priorities in RUN/FETCHSTOP: halt > data wait > branch flush > load-use > ifetch miss > normal.
REQ-005 Normal: every *_WEN=1, every *_flush=0, pc_WEN=1 (pc_WEN=0 in FETCHSTOP).
REQ-006 Data wait: when xmem_dreq=1 and dhit=0, SHALL drive all *_WEN=0 and pc_WEN=0 and enter DWAIT; DWAIT SHALL hold the freeze until dhit=1; the dhit cycle SHALL be evaluated as RUN/FETCHSTOP (the state returned to) with all lower priorities applied.
REQ-007 Branch: when br_taken=1 (and no data wait), SHALL assert ifid_flush, idex_flush and xmem_flush and pc_WEN=1; mwb advances normally; a branch flush in FETCHSTOP SHALL return to RUN (the halt was speculative).
REQ-008 Load-use: when idex_memread=1, idex_rt!=0 and idex_rt equals ifid_rs or ifid_rt, SHALL drive pc_WEN=0, ifid_WEN=0 and idex_flush=1 for exactly one cycle; xmem and mwb advance.
REQ-009 Ifetch miss: when ihit=0, SHALL drive pc_WEN=0 and ifid_flush=1 (bubble); downstream advances; ihit is ignored in FETCHSTOP.
REQ-010 When idex_halt_in=1 and the register advances, SHALL enter FETCHSTOP: pc_WEN=0 and ifid_flush=1 every cycle.
REQ-011 When mwb_halt_out=1, SHALL enter HALT: all *_WEN=0, pc_WEN=0, halted=1 until RST; HALT overrides a same-cycle dhit or br_taken.
REQ-012 Load-use and ifetch miss in the same cycle SHALL resolve as load-use only (IF/ID held, not flushed).

Reset
REQ-013 While RST=1: state=RUN, all *_WEN=0, all *_flush=1, pc_WEN=0, halted=0, counters=0; the first cycle after RST falls is evaluated as RUN.
REQ-014 RST asserted in any state (including DWAIT and HALT) SHALL take effect at the next edge.

Configuration
REQ-015 Macro PIPECTRL_PERF_EN defined: stall_cnt increments each cycle with pc_WEN=0 outside HALT and RST; flush_cnt increments once per br_taken flush cycle; both wrap modulo 2^CNT_W. Undefined: the ports and counters are absent, with no other behaviour change.

Structure
REQ-016 SHALL place the state enum pipectrl_state_t in cpu_types_pkg; no sub-module; the hazard compare SHALL be a local function.

Verification
REQ-017 xmem_dreq=1, dhit=0 for 3 cycles, then 1 -> all WEN=0 for 3 cycles, then normal; stall_cnt=3.
REQ-018 idex_memread=1, idex_rt=5, ifid_rs=5 -> one cycle pc_WEN=0, ifid_WEN=0, idex_flush=1; then normal. With idex_rt=0 -> no stall.
REQ-019 br_taken=1 with ihit=0 -> ifid/idex/xmem flush=1, pc_WEN=1; flush_cnt=1.
REQ-020 idex_halt_in=1, then br_taken=1 two cycles later -> FETCHSTOP for 2 cycles, then RUN, pc_WEN=1.
REQ-021 mwb_halt_out=1 with dhit=1 and br_taken=1 -> halted=1, all WEN=0, held until RST=1; the cycle after RST falls shows normal controls.
